// File: rtl/mult_div_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM state
// encoding, default operand width and the iteration-counter width rule.
package mult_div_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MRUN  = 3'd1,
    S_DRUN  = 3'd2,
    S_DONE  = 3'd3,
    S_DZERO = 3'd4,
    S_REARM = 3'd5
  } state_e;

  // The counter must be able to hold the value WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/md_shift_core.sv
// Shared iteration engine: 2W-bit accumulator/shift register, W+1-bit
// adder/subtractor and iteration counter used by both multiply and divide.
module md_shift_core
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   init_lo_i,
  input  logic [WIDTH-1:0]   opnd_i,
  output logic [2*WIDTH-1:0] acc_o,
  output logic               done_o
);

  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     lhs, rhs, sum;

  always_comb begin
    // Divide looks at the remainder already shifted left by one (W+1 bits);
    // multiply adds the multiplicand into the upper half when the LSB is set.
    lhs = div_i ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    rhs = (div_i || acc_q[0]) ? {1'b0, opnd_i} : '0;
    sum = lhs + (div_i ? ~rhs : rhs) + {{WIDTH{1'b0}}, div_i};

    acc_d = acc_q;
    cnt_d = cnt_q;
    if (load_i) begin
      acc_d = {{WIDTH{1'b0}}, init_lo_i};
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (div_i) begin
        acc_d = sum[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                           : {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = {sum, acc_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    acc_q <= acc_d;
  end

  assign acc_o  = acc_q;
  assign done_o = (cnt_q == CNT_W'(WIDTH));

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiply/divide unit: one shift-add or restoring-divide
// step per cycle, results on HIRes/LORes with a one-cycle completion pulse.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MultCtrl,
  input  logic             DivCtrl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             MultOut,
  output logic             DivOut,
  output logic             divZero,
  output logic             busy,
  output logic [WIDTH-1:0] HIRes,
  output logic [WIDTH-1:0] LORes
);

  function automatic logic [WIDTH-1:0] neg_w(input logic neg, input logic [WIDTH-1:0] v);
    return neg ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic neg,
                                                input logic [2*WIDTH-1:0] v);
    return neg ? (~v + {{(2*WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return neg_w(v[WIDTH-1], v);
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   opnd_q;
  logic               neg_lo_q, neg_hi_q;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               mult_out_q, mult_out_d;
  logic               div_out_q, div_out_d;
  logic               dz_q, dz_d;
  logic               req_any, b_zero, finish;
  logic               core_load, core_step, core_div, core_done;
  logic [WIDTH-1:0]   core_init;
  logic [2*WIDTH-1:0] core_acc, prod;

  assign req_any = MultCtrl || DivCtrl;
  assign b_zero  = (B == '0);

  md_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .load_i    (core_load),
    .step_i    (core_step),
    .div_i     (core_div),
    .init_lo_i (core_init),
    .opnd_i    (opnd_q),
    .acc_o     (core_acc),
    .done_o    (core_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (MultCtrl) begin
          state_d = S_MRUN;
        end else if (DivCtrl) begin
          state_d = b_zero ? S_DZERO : S_DRUN;
        end
      end
      S_MRUN, S_DRUN: begin
        if (core_done) state_d = S_DONE;
      end
      // A request still held after completion must not restart the operation.
      S_DONE, S_DZERO: state_d = req_any ? S_REARM : S_IDLE;
      S_REARM: begin
        if (!req_any) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == S_MRUN) || (state_q == S_DRUN);
    finish     = busy && core_done;
    mult_out_d = finish && (state_q == S_MRUN);
    div_out_d  = finish && (state_q == S_DRUN);
    dz_d       = (state_q == S_DZERO);
    core_load  = (state_q == S_IDLE) && (MultCtrl || (DivCtrl && !b_zero));
    core_step  = busy && !core_done;
    core_div   = (state_q == S_DRUN);
    core_init  = MultCtrl ? mag(B) : mag(A);
    prod       = neg_2w(neg_lo_q, core_acc);
    if (state_q == S_DRUN) begin
      hi_d = neg_w(neg_hi_q, core_acc[2*WIDTH-1:WIDTH]);
      lo_d = neg_w(neg_lo_q, core_acc[WIDTH-1:0]);
    end else begin
      hi_d = prod[2*WIDTH-1:WIDTH];
      lo_d = prod[WIDTH-1:0];
    end
  end

  // Operand magnitude and sign capture; only meaningful on the IDLE exit edge.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      opnd_q   <= MultCtrl ? mag(A) : mag(B);
      neg_lo_q <= A[WIDTH-1] ^ B[WIDTH-1];
      neg_hi_q <= MultCtrl ? (A[WIDTH-1] ^ B[WIDTH-1]) : A[WIDTH-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_out_q <= 1'b0;
      div_out_q  <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      mult_out_q <= mult_out_d;
      div_out_q  <= div_out_d;
      dz_q       <= dz_d;
      if (finish) begin
        hi_q <= hi_d;
        lo_q <= lo_d;
      end
    end
  end

  assign MultOut = mult_out_q;
  assign DivOut  = div_out_q;
  assign divZero = dz_q;
  assign HIRes   = hi_q;
  assign LORes   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: a driver issues requests and queues the
// arithmetically expected response; an independent monitor checks each pulse.
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          MultCtrl = 1'b0;
  logic          DivCtrl = 1'b0;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          MultOut, DivOut, divZero, busy;
  logic [W-1:0]  HIRes, LORes;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] cyc;
    logic [31:0] busy_cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          busy_cnt = 0;
  logic [31:0] cyc = 0;
  logic [31:0] last_hi = 0;
  logic [31:0] last_lo = 0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .MultCtrl (MultCtrl),
    .DivCtrl  (DivCtrl),
    .A        (A),
    .B        (B),
    .MultOut  (MultOut),
    .DivOut   (DivOut),
    .divZero  (divZero),
    .busy     (busy),
    .HIRes    (HIRes),
    .LORes    (LORes)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom();
    endcase
  endfunction

  // Issue one request the way the control unit does: hold the level until a
  // completion pulse, optionally keep holding, then drop it.
  task automatic run_op(input logic mul, input logic div, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t   e;
    longint sa, sbv, p, q, r;
    bit     seen;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    if (mul) begin
      p = sa * sbv;
      e.kind = 3'b100; e.hi = p[63:32]; e.lo = p[31:0];
      e.cyc = cyc + 1 + (W + 1); e.busy_cycles = W + 1;
      last_hi = e.hi; last_lo = e.lo;
    end else if (sbv == 0) begin
      e.kind = 3'b001; e.hi = last_hi; e.lo = last_lo;
      e.cyc = cyc + 2; e.busy_cycles = 0;
    end else begin
      q = sa / sbv;
      r = sa % sbv;
      e.kind = 3'b010; e.hi = r[31:0]; e.lo = q[31:0];
      e.cyc = cyc + 1 + (W + 1); e.busy_cycles = W + 1;
      last_hi = e.hi; last_lo = e.lo;
    end
    sb.push_back(e);
    A = a; B = b; MultCtrl = mul; DivCtrl = div;
    seen = 0;
    for (int i = 0; i < 3 * W; i++) begin
      @(negedge clk);
      if (i == 0) begin
        A = $urandom();
        B = $urandom();
      end
      if (MultOut || DivOut || divZero) begin
        seen = 1;
        break;
      end
    end
    check("completion-seen", 64'(seen), 64'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("busy-while-held", 64'(busy), 64'd0);
    end
    MultCtrl = 0; DivCtrl = 0;
    @(negedge clk);
  endtask

  // Monitor: every completion pulse is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        busy_cnt = 0;
      end else if (MultOut || DivOut || divZero) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected-pulse: got %b, expected none", {MultOut, DivOut, divZero});
        end else begin
          e = sb.pop_front();
          check("pulse-kind", 64'({MultOut, DivOut, divZero}), 64'(e.kind));
          check("HIRes", 64'(HIRes), 64'(e.hi));
          check("LORes", 64'(LORes), 64'(e.lo));
          check("latency", 64'(cyc), 64'(e.cyc));
          check("busy-cycles", 64'(busy_cnt), 64'(e.busy_cycles));
        end
        busy_cnt = 0;
      end else if (busy) begin
        busy_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    #1 reset = 0;
    repeat (3) @(negedge clk);
    check("rst-MultOut", 64'(MultOut), 64'd0);
    check("rst-DivOut", 64'(DivOut), 64'd0);
    check("rst-divZero", 64'(divZero), 64'd0);
    check("rst-busy", 64'(busy), 64'd0);
    check("rst-HIRes", 64'(HIRes), 64'd0);
    check("rst-LORes", 64'(LORes), 64'd0);
    reset = 1;
    @(negedge clk);

    run_op(1, 0, 32'd7, 32'hFFFF_FFFD, 0);
    run_op(1, 0, 32'h8000_0000, 32'h8000_0000, 0);
    run_op(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(0, 1, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(0, 1, 32'd5, 32'd0, 0);
    run_op(1, 0, 32'd12345, 32'hFFFF_FD4A, 3);
    run_op(1, 1, 32'h1234_5678, 32'h9ABC_DEF0, 0);

    // Reset in the middle of a divide: everything clears and nothing completes.
    A = 32'hFFFE_7960; B = 32'd7; DivCtrl = 1;
    repeat (11) @(negedge clk);
    check("busy-before-reset", 64'(busy), 64'd1);
    #2 reset = 0;
    #1;
    check("midrst-MultOut", 64'(MultOut), 64'd0);
    check("midrst-DivOut", 64'(DivOut), 64'd0);
    check("midrst-divZero", 64'(divZero), 64'd0);
    check("midrst-busy", 64'(busy), 64'd0);
    check("midrst-HIRes", 64'(HIRes), 64'd0);
    check("midrst-LORes", 64'(LORes), 64'd0);
    DivCtrl = 0;
    repeat (3) @(negedge clk);
    reset = 1;
    last_hi = 0; last_lo = 0;
    repeat (2) @(negedge clk);
    check("idle-after-reset", 64'(busy), 64'd0);

    run_op(0, 1, 32'd9, 32'd0, 0);
    run_op(0, 1, 32'd1000, 32'hFFFF_FFF9, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      int          sel;
      ra  = pick();
      rb  = pick();
      sel = $urandom_range(0, 2);
      run_op(sel == 0, sel != 0, ra, rb, $urandom_range(0, 2));
    end

    repeat (5) @(negedge clk);
    check("scoreboard-drained", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
